alu_shifter_cargabyte: RTL and testbench

ALU_SHIFTER_CARGABYTE -- requirements
Module: alu_shifter_cargabyte

---
 rtl/alu_shifter_cargabyte.sv | 112 +++++++++++
 tb/tb_alu_shifter_cargabyte.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_shifter_cargabyte.sv
// Datapath slice: barrel shifter, ALU with NZCV flags and a flag register, plus load byte extraction.
// Everything is combinational except the flag register.
module alu_shifter_cargabyte (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] sh_data,
  input  logic [4:0]  sh_amt,
  input  logic [1:0]  sh_type,
  input  logic        sh_en,
  output logic [31:0] sh_out,
  input  logic [31:0] src_a,
  input  logic [31:0] imm,
  input  logic        alu_src,
  input  logic [2:0]  alu_ctrl,
  output logic [31:0] alu_result,
  output logic [3:0]  alu_flags,
  input  logic [1:0]  flag_we,
  output logic [3:0]  flags,
  input  logic [31:0] rd_data,
  input  logic        byte_sel,
  input  logic [1:0]  byte_addr,
  output logic [31:0] load_out
);

  localparam int DATA_W = 32;

  function automatic logic [DATA_W-1:0] shift_op(input logic [DATA_W-1:0] d,
                                                 input logic [4:0] amt,
                                                 input logic [1:0] typ);
    logic signed [DATA_W-1:0] ds;
    logic [5:0]               lamt;
    logic [DATA_W-1:0]        r;
    ds   = d;
    lamt = 6'd32 - {1'b0, amt};
    case (typ)
      2'b00:   r = d << amt;
      2'b01:   r = d >> amt;
      2'b10:   r = ds >>> amt;
      default: r = (d >> amt) | (d << lamt);
    endcase
    return r;
  endfunction

  always_comb begin
    sh_out = sh_data;
    if (sh_en && (sh_amt != 5'd0))
      sh_out = shift_op(sh_data, sh_amt, sh_type);
  end

  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;
  logic              arith;
  logic              carry;
  logic              ovf;

  assign op_b = alu_src ? imm : sh_out;

  // SUB is folded into the adder as A + ~B + 1 so C and V come out of one carry chain.
  always_comb begin
    b_eff = (alu_ctrl == 3'b001) ? ~op_b : op_b;
    sum   = {1'b0, src_a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, (alu_ctrl == 3'b001)};
    arith = (alu_ctrl == 3'b000) || (alu_ctrl == 3'b001);
  end

  always_comb begin
    alu_result = '0;
    carry      = 1'b0;
    ovf        = 1'b0;
    case (alu_ctrl)
      3'b000, 3'b001: begin
        alu_result = sum[DATA_W-1:0];
        carry      = sum[DATA_W];
        ovf        = (src_a[DATA_W-1] == b_eff[DATA_W-1]) &&
                     (sum[DATA_W-1] != src_a[DATA_W-1]);
      end
      3'b010:  alu_result = src_a & op_b;
      3'b011:  alu_result = src_a | op_b;
      3'b100:  alu_result = src_a ^ op_b;
      default: alu_result = '0;
    endcase
    if (!arith) begin
      carry = 1'b0;
      ovf   = 1'b0;
    end
  end

  assign alu_flags = {alu_result[DATA_W-1], (alu_result == '0), carry, ovf};

  // NZ and CV have independent write enables so logic ops can leave C,V untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= 4'b0000;
    end else begin
      if (flag_we[1]) flags[3:2] <= alu_flags[3:2];
      if (flag_we[0]) flags[1:0] <= alu_flags[1:0];
    end
  end

  always_comb begin
    load_out = rd_data;
    if (byte_sel) begin
      case (byte_addr)
        2'b00:   load_out = {24'b0, rd_data[7:0]};
        2'b01:   load_out = {24'b0, rd_data[15:8]};
        2'b10:   load_out = {24'b0, rd_data[23:16]};
        default: load_out = {24'b0, rd_data[31:24]};
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shifter_cargabyte.sv
// Directed-vector bench for alu_shifter_cargabyte with hand-computed expectations.
module tb_alu_shifter_cargabyte;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] sh_data = '0;
  logic [4:0]  sh_amt = '0;
  logic [1:0]  sh_type = '0;
  logic        sh_en = 1'b0;
  logic [31:0] sh_out;
  logic [31:0] src_a = '0;
  logic [31:0] imm = '0;
  logic        alu_src = 1'b0;
  logic [2:0]  alu_ctrl = '0;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;
  logic [1:0]  flag_we = '0;
  logic [3:0]  flags;
  logic [31:0] rd_data = '0;
  logic        byte_sel = 1'b0;
  logic [1:0]  byte_addr = '0;
  logic [31:0] load_out;

  int vectors = 0;
  int miscompares = 0;

  alu_shifter_cargabyte dut (
    .clk(clk), .reset(reset),
    .sh_data(sh_data), .sh_amt(sh_amt), .sh_type(sh_type), .sh_en(sh_en), .sh_out(sh_out),
    .src_a(src_a), .imm(imm), .alu_src(alu_src), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .flag_we(flag_we), .flags(flags),
    .rd_data(rd_data), .byte_sel(byte_sel), .byte_addr(byte_addr), .load_out(load_out)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #1;
    vectors++;
    if (flags !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_initial flags=%b expected=0000", flags);
    end
    // Drive a flag-setting op while reset is held across a clock edge.
    @(negedge clk);
    src_a = 32'h7FFFFFFF; imm = 32'h1; alu_src = 1'b1; alu_ctrl = 3'b000; flag_we = 2'b11;
    @(posedge clk); #1;
    vectors++;
    if (flags !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_hold flags=%b expected=0000", flags);
    end
    vectors++;
    if (alu_result !== 32'h80000000 || alu_flags !== 4'b1001) begin
      miscompares++;
      $display("FAIL reset_comb_live result=%h flags=%b expected=80000000 1001", alu_result, alu_flags);
    end
    @(negedge clk);
    flag_we = 2'b00;
    reset = 1'b0;
  endtask

  task automatic test_shifter();
    logic [31:0] d   [10];
    logic [4:0]  a   [10];
    logic [1:0]  t   [10];
    logic        e   [10];
    logic [31:0] exp [10];
    d = '{32'h80000001, 32'h80000001, 32'h80000001, 32'h80000001,
          32'h80000001, 32'h80000001, 32'h80000001, 32'h80000001,
          32'h12345678, 32'h12345678};
    a = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd31, 5'd31, 5'd31, 5'd31, 5'd4, 5'd0};
    t = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10};
    e = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp = '{32'hC0000000, 32'hC0000000, 32'h40000000, 32'h00000002,
            32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h00000003,
            32'h12345678, 32'h12345678};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sh_data = d[i]; sh_amt = a[i]; sh_type = t[i]; sh_en = e[i];
      #1;
      vectors++;
      if (sh_out !== exp[i]) begin
        miscompares++;
        $display("FAIL shift_%0d sh_out=%h expected=%h", i, sh_out, exp[i]);
      end
    end
  endtask

  task automatic test_alu_arith();
    logic [31:0] av  [5];
    logic [31:0] bv  [5];
    logic [2:0]  cv  [5];
    logic [31:0] er  [5];
    logic [3:0]  ef  [5];
    av = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'd3, 32'h80000000, 32'd5};
    bv = '{32'd1, 32'd1, 32'd5, 32'd1, 32'd5};
    cv = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001};
    er = '{32'h80000000, 32'h0, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'h0};
    ef = '{4'b1001, 4'b0110, 4'b1000, 4'b0011, 4'b0110};
    alu_src = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      src_a = av[i]; imm = bv[i]; alu_ctrl = cv[i];
      #1;
      vectors++;
      if (alu_result !== er[i] || alu_flags !== ef[i]) begin
        miscompares++;
        $display("FAIL arith_%0d result=%h flags=%b expected=%h %b", i, alu_result, alu_flags, er[i], ef[i]);
      end
    end
    // Operand B taken from the shifter: 10 + (1 << 2).
    @(negedge clk);
    alu_src = 1'b0; src_a = 32'd10; sh_data = 32'd1; sh_amt = 5'd2; sh_type = 2'b00; sh_en = 1'b1;
    alu_ctrl = 3'b000; imm = 32'hDEADBEEF;
    #1;
    vectors++;
    if (alu_result !== 32'd14) begin
      miscompares++;
      $display("FAIL arith_shifted_b result=%h expected=0000000e", alu_result);
    end
  endtask

  task automatic test_alu_logic();
    logic [2:0]  cv [4];
    logic [31:0] er [4];
    logic [3:0]  ef [4];
    cv = '{3'b010, 3'b011, 3'b100, 3'b111};
    er = '{32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'h0};
    ef = '{4'b1000, 4'b1000, 4'b0000, 4'b0100};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      alu_src = 1'b1; src_a = 32'hF0F0F0F0; imm = 32'hFF00FF00; alu_ctrl = cv[i];
      #1;
      vectors++;
      if (alu_result !== er[i] || alu_flags !== ef[i]) begin
        miscompares++;
        $display("FAIL logic_%0d result=%h flags=%b expected=%h %b", i, alu_result, alu_flags, er[i], ef[i]);
      end
    end
  endtask

  task automatic test_flags();
    @(negedge clk);
    alu_src = 1'b1; src_a = 32'd5; imm = 32'd5; alu_ctrl = 3'b001; flag_we = 2'b11;
    @(posedge clk); #1;
    vectors++;
    if (alu_result !== 32'h0 || flags !== 4'b0110) begin
      miscompares++;
      $display("FAIL flags_sub_eq result=%h flags=%b expected=00000000 0110", alu_result, flags);
    end
    @(negedge clk);
    src_a = 32'h7FFFFFFF; imm = 32'd1; alu_ctrl = 3'b000; flag_we = 2'b10;
    @(posedge clk); #1;
    vectors++;
    if (flags !== 4'b1010) begin
      miscompares++;
      $display("FAIL flags_nz_only flags=%b expected=1010", flags);
    end
    @(negedge clk);
    flag_we = 2'b01;
    @(posedge clk); #1;
    vectors++;
    if (flags !== 4'b1001) begin
      miscompares++;
      $display("FAIL flags_cv_only flags=%b expected=1001", flags);
    end
    @(negedge clk);
    src_a = 32'd0; imm = 32'd0; flag_we = 2'b00;
    @(posedge clk); #1;
    vectors++;
    if (flags !== 4'b1001) begin
      miscompares++;
      $display("FAIL flags_hold flags=%b expected=1001", flags);
    end
  endtask

  task automatic test_load();
    logic [1:0]  ad  [5];
    logic        bs  [5];
    logic [31:0] exp [5];
    ad  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
    bs  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp = '{32'h44, 32'h33, 32'h22, 32'h11, 32'h11223344};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rd_data = 32'h11223344; byte_sel = bs[i]; byte_addr = ad[i];
      #1;
      vectors++;
      if (load_out !== exp[i]) begin
        miscompares++;
        $display("FAIL load_%0d load_out=%h expected=%h", i, load_out, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    alu_src = 1'b1; src_a = 32'h7FFFFFFF; imm = 32'd1; alu_ctrl = 3'b000; flag_we = 2'b11;
    @(posedge clk); #1;
    vectors++;
    if (flags !== 4'b1001) begin
      miscompares++;
      $display("FAIL reset_mid_pre flags=%b expected=1001", flags);
    end
    // Assert reset between edges; flags must clear without waiting for clk.
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (flags !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_mid_async flags=%b expected=0000", flags);
    end
    @(negedge clk);
    reset = 1'b0; flag_we = 2'b00;
  endtask

  initial begin
    test_reset();
    test_shifter();
    test_alu_arith();
    test_alu_logic();
    test_flags();
    test_load();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
